fetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the RISCV core. It replaces the bare program-counter register with a fetch engine that does several things:
- issues pipelined requests to instruction memory over a valid/ready interface;
- tags each request with its PC;
- buffers in-order responses in a small ring buffer;
- hands instructions to decode over a valid/ready interface;
- supports redirect (branch/jump) with discard of in-flight responses.

---
 rtl/riscv_pkg.sv | 12 +
 rtl/fetch_buffer.sv | 77 +++++++
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISCV front end.
package riscv_pkg;

    localparam int unsigned INSTR_BITS  = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [0:0] {
        RUN,
        DRAIN
    } fetch_mode_t;

endpackage

// File: rtl/fetch_buffer.sv
// In-order ring buffer of fetched instructions: entries are allocated at issue,
// filled by memory responses and released by decode.
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int unsigned REG_BITS  = 32,
    parameter int unsigned BUF_DEPTH = 4,
    localparam int unsigned IDX_BITS = $clog2(BUF_DEPTH),
    localparam int unsigned CNT_BITS = IDX_BITS + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  alloc,
    input  logic [REG_BITS-1:0]   alloc_pc,
    input  logic                  fill,
    input  logic [INSTR_BITS-1:0] fill_data,
    input  logic                  consume,
    output logic                  out_valid,
    output logic [REG_BITS-1:0]   out_pc,
    output logic [INSTR_BITS-1:0] out_data,
    output logic [CNT_BITS-1:0]   alloc_cnt,
    output logic [CNT_BITS-1:0]   pending_cnt
);

    logic [REG_BITS-1:0]   pc_q   [BUF_DEPTH];
    logic [INSTR_BITS-1:0] data_q [BUF_DEPTH];
    logic [BUF_DEPTH-1:0]  filled_q;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [CNT_BITS-1:0] alloc_ptr_q, fill_ptr_q, read_ptr_q;
    logic [IDX_BITS-1:0] alloc_idx, fill_idx, read_idx;

    assign alloc_idx   = alloc_ptr_q[IDX_BITS-1:0];
    assign fill_idx    = fill_ptr_q[IDX_BITS-1:0];
    assign read_idx    = read_ptr_q[IDX_BITS-1:0];
    assign alloc_cnt   = alloc_ptr_q - read_ptr_q;
    assign pending_cnt = alloc_ptr_q - fill_ptr_q;

    assign out_valid = filled_q[read_idx] && (alloc_cnt != '0);
    assign out_pc    = pc_q[read_idx];
    assign out_data  = data_q[read_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            filled_q    <= '0;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            read_ptr_q  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                pc_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else if (flush) begin
            filled_q   <= '0;
            fill_ptr_q <= alloc_ptr_q;
            read_ptr_q <= alloc_ptr_q;
        end else begin
            // Alloc, fill and consume always address distinct entries.
            if (alloc) begin
                pc_q[alloc_idx]     <= alloc_pc;
                filled_q[alloc_idx] <= 1'b0;
                alloc_ptr_q         <= alloc_ptr_q + CNT_BITS'(1);
            end
            if (fill) begin
                data_q[fill_idx]   <= fill_data;
                filled_q[fill_idx] <= 1'b1;
                fill_ptr_q         <= fill_ptr_q + CNT_BITS'(1);
            end
            if (consume) begin
                filled_q[read_idx] <= 1'b0;
                read_ptr_q         <= read_ptr_q + CNT_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch engine: pipelined imem requests, in-order response buffering,
// decode hand-off and redirect with discard of stale in-flight responses.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned         REG_BITS     = 32,
    parameter logic [REG_BITS-1:0] RESET_VECTOR = '0,
    parameter int unsigned         BUF_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [REG_BITS-1:0]   imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INSTR_BITS-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [REG_BITS-1:0]   redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [INSTR_BITS-1:0] instr,
    output logic [REG_BITS-1:0]   instr_pc
);

    localparam int unsigned         CNT_BITS = $clog2(BUF_DEPTH) + 1;
    localparam logic [REG_BITS-1:0] PC_STEP  = REG_BITS'(INSTR_BYTES);
    localparam logic [CNT_BITS:0]   DEPTH_C  = (CNT_BITS + 1)'(BUF_DEPTH);

    logic [REG_BITS-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_BITS-1:0] drop_cnt_q, drop_cnt_d;
    fetch_mode_t         mode_q, mode_d;

    logic [CNT_BITS-1:0] alloc_cnt, pending_cnt;
    logic [CNT_BITS:0]   credit_used;
    logic                issue, rsp_fill, dec_fire;
    logic                unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    // Buffered entries and responses still to discard share the same credit pool.
    assign credit_used    = {1'b0, alloc_cnt} + {1'b0, drop_cnt_q};
    assign imem_req_valid = !rst && !redirect_valid && (credit_used < DEPTH_C);
    assign imem_addr      = fetch_pc_q;
    assign issue          = imem_req_valid && imem_req_ready;
    assign rsp_fill       = imem_rsp_valid && (mode_q == RUN) && !redirect_valid;
    assign dec_fire       = instr_valid && instr_ready;

    fetch_buffer #(
        .REG_BITS (REG_BITS),
        .BUF_DEPTH(BUF_DEPTH)
    ) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .alloc      (issue),
        .alloc_pc   (fetch_pc_q),
        .fill       (rsp_fill),
        .fill_data  (imem_rsp_data),
        .consume    (dec_fire),
        .out_valid  (instr_valid),
        .out_pc     (instr_pc),
        .out_data   (instr),
        .alloc_cnt  (alloc_cnt),
        .pending_cnt(pending_cnt)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[REG_BITS-1:2], 2'b00};
            // A response arriving now retires one of the outstanding requests.
            drop_cnt_d = drop_cnt_q + pending_cnt - CNT_BITS'(imem_rsp_valid);
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (imem_rsp_valid && (mode_q == DRAIN)) begin
                drop_cnt_d = drop_cnt_q - CNT_BITS'(1);
            end
        end
    end

    always_comb begin
        mode_d = mode_q;
        unique case (mode_q)
            RUN:     if (drop_cnt_d != '0) mode_d = DRAIN;
            DRAIN:   if (drop_cnt_d == '0) mode_d = RUN;
            default: mode_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_VECTOR;
            drop_cnt_q <= '0;
            mode_q     <= RUN;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
            mode_q     <= mode_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable in-order imem model.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid, instr_ready = 1'b0;
    logic [31:0] instr, instr_pc;

    logic        w_req_valid;
    logic [31:0] w_addr;
    logic        w_rsp_valid = 1'b0;
    logic [31:0] w_rsp_data = '0;
    logic        w_instr_valid;
    logic [31:0] w_instr, w_instr_pc;

    fetch_unit #(.REG_BITS(32), .RESET_VECTOR(32'h0000_0000), .BUF_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
    );

    fetch_unit #(.REG_BITS(32), .RESET_VECTOR(32'hFFFF_FFF8), .BUF_DEPTH(4)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
        .imem_addr(w_addr), .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .instr_valid(w_instr_valid), .instr_ready(1'b1), .instr(w_instr), .instr_pc(w_instr_pc)
    );

    localparam logic [31:0] KEY  = 32'hA5A5_0000;
    localparam logic [31:0] NONE = 32'hDEAD_DEAD;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; int at; } dec_t;

    mreq_t       mq[$];
    dec_t        dlog[$];
    logic [31:0] rlog[$];
    logic [31:0] wlog[$];
    int          edge_n = 0;
    int          lat = 1;
    logic        w_pend = 1'b0;
    logic [31:0] w_pend_addr = '0;

    int total = 0;
    int bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dpc(input int i);
        return (dlog.size() > i) ? dlog[i].pc : NONE;
    endfunction
    function automatic logic [31:0] ddat(input int i);
        return (dlog.size() > i) ? dlog[i].data : NONE;
    endfunction
    function automatic logic [31:0] rq(input int i);
        return (rlog.size() > i) ? rlog[i] : NONE;
    endfunction
    function automatic logic [31:0] wq(input int i);
        return (wlog.size() > i) ? wlog[i] : NONE;
    endfunction

    // Handshakes are sampled at the active edge, before state updates land.
    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            mq.delete();
            w_pend = 1'b0;
            wlog.delete();
        end else begin
            if (imem_rsp_valid) void'(mq.pop_front());
            if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{imem_addr, edge_n + lat});
                rlog.push_back(imem_addr);
            end
            if (instr_valid && instr_ready) dlog.push_back('{instr_pc, instr, edge_n});
            w_pend      = w_req_valid;
            w_pend_addr = w_addr;
            if (w_req_valid) wlog.push_back(w_addr);
        end
    end

    always @(negedge clk) begin
        if (!rst && mq.size() > 0 && mq[0].due <= edge_n + 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq[0].addr ^ KEY;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        w_rsp_valid = w_pend && !rst;
        w_rsp_data  = w_pend_addr ^ KEY;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input int lat_v, input logic ready_v);
        rst         = 1'b1;
        lat         = lat_v;
        instr_ready = ready_v;
        tick(2);
        rst = 1'b0;
        dlog.delete();
        rlog.delete();
        #1;
    endtask

    initial begin
        // Reset state and back-to-back throughput
        tick(2);
        check_eq("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check_eq("rst_addr", imem_addr, 32'h0);
        check_eq("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_instr_pc", instr_pc, 32'h0);
        check_eq("wrap_rst_addr", w_addr, 32'hFFFF_FFF8);
        check_eq("wrap_rst_req_valid", {31'b0, w_req_valid}, 32'h0);
        lat         = 1;
        instr_ready = 1'b1;
        rst         = 1'b0;
        #1;
        check_eq("first_req_valid", {31'b0, imem_req_valid}, 32'h1);
        check_eq("first_req_addr", imem_addr, 32'h0);
        tick(7);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("tput_pc%0d", i), dpc(i), 32'(4 * i));
            check_eq($sformatf("tput_data%0d", i), ddat(i), 32'(4 * i) ^ KEY);
        end
        check_eq("tput_back_to_back",
                 (dlog.size() >= 4) ? 32'(dlog[3].at - dlog[0].at) : NONE, 32'd3);
        check_eq("wrap_req0", wq(0), 32'hFFFF_FFF8);
        check_eq("wrap_req1", wq(1), 32'hFFFF_FFFC);
        check_eq("wrap_req2", wq(2), 32'h0000_0000);

        // Decode stalled: buffer fills after four requests
        do_reset(1, 1'b0);
        tick(8);
        check_eq("full_req_count", 32'(rlog.size()), 32'd4);
        check_eq("full_last_addr", rq(3), 32'd12);
        check_eq("full_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check_eq("full_instr_valid", {31'b0, instr_valid}, 32'h1);
        instr_ready = 1'b1;
        tick(1);
        check_eq("free_req_valid", {31'b0, imem_req_valid}, 32'h1);
        check_eq("free_req_addr", imem_addr, 32'd16);
        tick(4);
        check_eq("free_req4", rq(4), 32'd16);
        check_eq("free_req5", rq(5), 32'd20);
        check_eq("free_dec0", dpc(0), 32'd0);

        // Reset pulse while the buffer is full
        do_reset(1, 1'b0);
        tick(8);
        rst = 1'b1;
        tick(1);
        check_eq("midrst_instr_valid", {31'b0, instr_valid}, 32'h0);
        check_eq("midrst_instr", instr, 32'h0);
        check_eq("midrst_instr_pc", instr_pc, 32'h0);
        check_eq("midrst_addr", imem_addr, 32'h0);
        rst = 1'b0;
        dlog.delete();
        rlog.delete();
        instr_ready = 1'b1;
        #1;
        check_eq("midrst_req_valid", {31'b0, imem_req_valid}, 32'h1);
        tick(4);
        check_eq("midrst_dec0_pc", dpc(0), 32'd0);
        check_eq("midrst_dec0_data", ddat(0), KEY);
        check_eq("midrst_dec1_pc", dpc(1), 32'd4);

        // Redirect with three requests outstanding, no response that cycle
        do_reset(4, 1'b1);
        tick(3);
        check_eq("redir_outstanding", 32'(rlog.size()), 32'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        #1;
        check_eq("redir_no_issue", {31'b0, imem_req_valid}, 32'h0);
        tick(1);
        redirect_valid = 1'b0;
        #1;
        check_eq("redir_instr_valid", {31'b0, instr_valid}, 32'h0);
        check_eq("redir_req_valid", {31'b0, imem_req_valid}, 32'h1);
        check_eq("redir_addr", imem_addr, 32'h0000_0200);
        tick(10);
        check_eq("redir_dec0_pc", dpc(0), 32'h0000_0200);
        check_eq("redir_dec0_data", ddat(0), 32'h0000_0200 ^ KEY);
        check_eq("redir_dec1_pc", dpc(1), 32'h0000_0204);

        // Redirect coinciding with a response and a decode handshake
        do_reset(2, 1'b1);
        tick(3);
        check_eq("coin_pre_valid", {31'b0, instr_valid}, 32'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick(1);
        redirect_valid = 1'b0;
        #1;
        check_eq("coin_instr_valid", {31'b0, instr_valid}, 32'h0);
        check_eq("coin_addr", imem_addr, 32'h0000_0100);
        tick(8);
        check_eq("coin_dec0_pc", dpc(0), 32'h0);
        check_eq("coin_dec1_pc", dpc(1), 32'h0000_0100);
        check_eq("coin_dec1_data", ddat(1), 32'h0000_0100 ^ KEY);
        check_eq("coin_dec2_pc", dpc(2), 32'h0000_0104);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
